lcd_frame_receiver: RTL

//  Panel-side receiver for the LCD parallel pixel bus (data, update, valid, invert).

---
 rtl/lcd_frame_receiver_pkg.sv | 33 +++
 rtl/lcd_frame_receiver_if.sv | 16 +
 rtl/lcd_frame_receiver_position.sv | 61 ++++++
 rtl/lcd_frame_receiver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lcd_frame_receiver_pkg.sv
// Shared timing defaults, state encoding and error-bit positions for the LCD
// frame receiver; the driver side uses the same definitions.
package lcd_frame_receiver_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_LINES          = 1280;
  localparam int unsigned DEF_CLKS_PER_LINE  = 44;
  localparam int unsigned DEF_WORDS_PER_LINE = 40;
  localparam int unsigned DEF_UPDATE_CLKS    = 48;
  localparam int unsigned DEF_PORCH_CLKS     = 24;

  localparam int unsigned WORD_W = 6;
  localparam int unsigned LINE_W = 11;
  localparam int unsigned ERR_W  = 4;

  localparam int unsigned ERR_UPDATE   = 0;
  localparam int unsigned ERR_VALID    = 1;
  localparam int unsigned ERR_LENGTH   = 2;
  localparam int unsigned ERR_POLARITY = 3;

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_DATA  = 2'd1,
    S_PORCH = 2'd2
  } rxState_t;

  function automatic int unsigned frameClks(input int unsigned lines,
                                            input int unsigned clksPerLine,
                                            input int unsigned porchClks);
    return lines * clksPerLine + porchClks;
  endfunction

endpackage

// File: rtl/lcd_frame_receiver_if.sv
// LCD parallel pixel bus: driver is the master, panel/receiver is the slave.
interface lcd_frame_receiver_if
  import lcd_frame_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  update;
  logic                  valid;
  logic                  invert;

  modport master (output data, output update, output valid, output invert);
  modport slave  (input  data, input  update, input  valid, input  invert);

endinterface

// File: rtl/lcd_frame_receiver_position.sv
// Word/line/frame-clock position tracker. Outputs describe the sample being
// taken this clock; a restart forces that sample to position zero.
module lcd_position_counter
  import lcd_frame_receiver_pkg::*;
#(
  parameter int unsigned LINES         = DEF_LINES,
  parameter int unsigned CLKS_PER_LINE = DEF_CLKS_PER_LINE,
  parameter int unsigned CLK_W         = 17
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              run,
  input  logic              restart,
  output logic [WORD_W-1:0] wordIndex,
  output logic [LINE_W-1:0] lineIndex,
  output logic [CLK_W-1:0]  frameClk,
  output logic [CLK_W-1:0]  rawClk,
  output logic              endOfLine,
  output logic              endOfData,
  output logic              inData
);

  localparam logic [CLK_W-1:0]  DATA_END  = CLK_W'(LINES * CLKS_PER_LINE);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(CLKS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  logic [WORD_W-1:0] wordReg;
  logic [LINE_W-1:0] lineReg;
  logic [CLK_W-1:0]  clkReg;

  always_comb begin
    wordIndex = restart ? '0 : wordReg;
    lineIndex = restart ? '0 : lineReg;
    frameClk  = restart ? '0 : clkReg;
    rawClk    = clkReg;
    inData    = frameClk < DATA_END;
    endOfLine = inData && (wordIndex == LAST_WORD);
    endOfData = endOfLine && (lineIndex == LAST_LINE);
  end

  // Word/line freeze at zero through the porch once the last line has ended.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wordReg <= '0;
      lineReg <= '0;
      clkReg  <= '0;
    end else if (run) begin
      clkReg <= frameClk + 1'b1;
      if (inData) begin
        wordReg <= endOfLine ? '0 : wordIndex + 1'b1;
        if (endOfData)
          lineReg <= '0;
        else if (endOfLine)
          lineReg <= lineIndex + 1'b1;
        else
          lineReg <= lineIndex;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_receiver.sv
// Panel-side receiver for the LCD pixel bus: locks to frame timing, re-emits
// valid pixel words with their position and flags protocol violations.
module lcd_frame_receiver
  import lcd_frame_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned LINES          = DEF_LINES,
  parameter int unsigned CLKS_PER_LINE  = DEF_CLKS_PER_LINE,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned UPDATE_CLKS    = DEF_UPDATE_CLKS,
  parameter int unsigned PORCH_CLKS     = DEF_PORCH_CLKS
) (
  input  logic                  i_clock,
  input  logic                  i_nreset,
  lcd_frame_receiver_if.slave   lcdBus,
  input  logic                  i_clearErrors,
  output logic [DATA_WIDTH-1:0] o_pixelData,
  output logic                  o_pixelValid,
  output logic [WORD_W-1:0]     o_wordIndex,
  output logic [LINE_W-1:0]     o_lineIndex,
  output logic                  o_frameStart,
  output logic                  o_frameDone,
  output logic                  o_frameNormal,
  output logic                  o_locked,
  output logic [ERR_W-1:0]      o_error,
  output logic [15:0]           o_frameCount
);

  localparam int unsigned FRAME_CLKS = frameClks(LINES, CLKS_PER_LINE, PORCH_CLKS);
  localparam int unsigned CLK_W      = $clog2(FRAME_CLKS + PORCH_CLKS + 2);
  localparam int unsigned UPD_W      = $clog2(UPDATE_CLKS + 2);
  localparam int unsigned VCNT_W     = $clog2(CLKS_PER_LINE + 1);

  localparam logic [CLK_W-1:0]  CLK_DONE    = CLK_W'(FRAME_CLKS - 1);
  localparam logic [CLK_W-1:0]  CLK_NEXT    = CLK_W'(FRAME_CLKS);
  localparam logic [CLK_W-1:0]  CLK_TIMEOUT = CLK_W'(FRAME_CLKS + PORCH_CLKS);
  localparam logic [UPD_W-1:0]  UPD_LEN     = UPD_W'(UPDATE_CLKS);
  localparam logic [VCNT_W-1:0] LINE_WORDS  = VCNT_W'(WORDS_PER_LINE);
  localparam logic [WORD_W-1:0] FIRST_IDLE  = WORD_W'(WORDS_PER_LINE);

  rxState_t state, stateNext;

  logic              updPrev;
  logic              updSeen;
  logic [UPD_W-1:0]  updLen;
  logic [VCNT_W-1:0] lineValid;
  logic [VCNT_W-1:0] lineValidNow;

  logic              rise;
  logic              fall;
  logic              active;
  logic              curNormal;
  logic              pixelValidNow;
  logic              frameDoneNow;
  logic [ERR_W-1:0]  newErr;

  logic [WORD_W-1:0] curWord;
  logic [LINE_W-1:0] curLine;
  logic [CLK_W-1:0]  curClk;
  logic [CLK_W-1:0]  rawClk;
  logic              endOfLine;
  logic              endOfData;
  logic              inData;

  lcd_position_counter #(
    .LINES         (LINES),
    .CLKS_PER_LINE (CLKS_PER_LINE),
    .CLK_W         (CLK_W)
  ) u_position (
    .clock     (i_clock),
    .nreset    (i_nreset),
    .run       (active),
    .restart   (rise),
    .wordIndex (curWord),
    .lineIndex (curLine),
    .frameClk  (curClk),
    .rawClk    (rawClk),
    .endOfLine (endOfLine),
    .endOfData (endOfData),
    .inData    (inData)
  );

  always_comb begin
    rise          = lcdBus.update & ~updPrev;
    fall          = ~lcdBus.update & updPrev;
    active        = (state != S_HUNT) | rise;
    curNormal     = rise ? lcdBus.invert : o_frameNormal;
    lineValidNow  = ((rise || curWord == '0) ? '0 : lineValid) + VCNT_W'(lcdBus.valid);
    pixelValidNow = lcdBus.valid & active & curNormal & inData;
  end

  always_comb begin
    stateNext    = state;
    newErr       = '0;
    frameDoneNow = 1'b0;

    unique case (state)
      S_HUNT: begin
        if (rise) stateNext = S_DATA;
      end
      S_DATA: begin
        if (rise) begin
          newErr[ERR_LENGTH] = 1'b1;
        end else if (endOfData) begin
          stateNext = S_PORCH;
        end
      end
      S_PORCH: begin
        if (rise) begin
          stateNext = S_DATA;
          if (rawClk != CLK_NEXT) newErr[ERR_LENGTH] = 1'b1;
        end else if (rawClk == CLK_TIMEOUT) begin
          stateNext          = S_HUNT;
          newErr[ERR_LENGTH] = 1'b1;
        end else if (rawClk == CLK_DONE) begin
          frameDoneNow = 1'b1;
        end
      end
      default: stateNext = S_HUNT;
    endcase

    // Polarity history is only meaningful while locked.
    if (rise && state != S_HUNT && lcdBus.invert == o_frameNormal)
      newErr[ERR_POLARITY] = 1'b1;

    if (fall && updSeen && updLen != UPD_LEN)
      newErr[ERR_UPDATE] = 1'b1;

    if (active && lcdBus.valid && (!inData || !curNormal || curWord >= FIRST_IDLE))
      newErr[ERR_VALID] = 1'b1;
    if (active && curNormal && endOfLine && lineValidNow != LINE_WORDS)
      newErr[ERR_VALID] = 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      state         <= S_HUNT;
      updPrev       <= 1'b0;
      updSeen       <= 1'b0;
      updLen        <= '0;
      lineValid     <= '0;
      o_pixelData   <= '0;
      o_pixelValid  <= 1'b0;
      o_wordIndex   <= '0;
      o_lineIndex   <= '0;
      o_frameStart  <= 1'b0;
      o_frameDone   <= 1'b0;
      o_frameNormal <= 1'b0;
      o_locked      <= 1'b0;
      o_error       <= '0;
      o_frameCount  <= '0;
    end else begin
      state   <= stateNext;
      updPrev <= lcdBus.update;
      updSeen <= updSeen | rise;

      if (rise)
        updLen <= UPD_W'(1);
      else if (lcdBus.update && updLen != '1)
        updLen <= updLen + 1'b1;

      if (active) lineValid <= lineValidNow;

      o_pixelValid <= pixelValidNow;
      if (pixelValidNow) o_pixelData <= lcdBus.data;
      o_wordIndex  <= active ? curWord : '0;
      o_lineIndex  <= active ? curLine : '0;
      o_frameStart <= rise;
      o_frameDone  <= frameDoneNow;
      if (rise) o_frameNormal <= lcdBus.invert;
      o_locked     <= (stateNext != S_HUNT);
      o_error      <= (i_clearErrors ? '0 : o_error) | newErr;
      if (frameDoneNow && o_frameNormal) o_frameCount <= o_frameCount + 1'b1;
    end
  end

endmodule
